// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding, {R,Y,G} lamp patterns and default timings
// for the traffic phase sequencer and its helpers.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_EMG_CLEAR,
    ST_EMG_GREEN
  } tlc_state_e;

  // Lamp triplets, ordered {R,Y,G}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Default geometry and durations (durations in ticks).
  localparam int DEF_N_DIR      = 4;
  localparam int DEF_TW         = 8;
  localparam int DEF_YEL_T      = 2;
  localparam int DEF_ALLRED_T   = 1;
  localparam int DEF_EMG_HOLD_T = 3;

  // Lamp shown on the served approach; every other approach is always red.
  function automatic logic [2:0] served_lamp(tlc_state_e st);
    case (st)
      ST_GREEN, ST_EMG_GREEN:  served_lamp = LAMP_GRN;
      ST_YELLOW, ST_EMG_CLEAR: served_lamp = LAMP_YEL;
      default:                 served_lamp = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_next_dir.sv
// tlc_next_dir: picks the approach that follows cur_dir_i.
// With TLC_DEMAND_SKIP_EN defined, the first approach after cur_dir_i (cyclic)
// with vehicle demand is chosen and has_next_o drops when no other approach
// has demand. Without it, next is simply cur_dir_i+1 modulo N_DIR.
module tlc_next_dir #(
  parameter int N_DIR = 4,
  parameter int DW    = $clog2(N_DIR)
) (
  input  logic [DW-1:0]    cur_dir_i,
  input  logic [N_DIR-1:0] vehicle_present_i,
  output logic [DW-1:0]    next_dir_o,
  output logic             has_next_o
);

`ifdef TLC_DEMAND_SKIP_EN
  function automatic logic [DW-1:0] wrap_add(logic [DW-1:0] d, int off);
    int s;
    s = int'(d) + off;
    if (s >= N_DIR) s = s - N_DIR;
    return s[DW-1:0];
  endfunction

  // Priority rotate: scan farthest offset first so the nearest demand wins.
  always_comb begin
    next_dir_o = cur_dir_i;
    has_next_o = 1'b0;
    for (int off = N_DIR - 1; off >= 1; off--) begin
      if (vehicle_present_i[wrap_add(cur_dir_i, off)]) begin
        next_dir_o = wrap_add(cur_dir_i, off);
        has_next_o = 1'b1;
      end
    end
  end
`else
  // Plain round robin; demand inputs have no effect in this build.
  logic unused_vp;
  assign unused_vp  = ^vehicle_present_i;
  assign next_dir_o = (cur_dir_i == DW'(N_DIR - 1)) ? '0 : cur_dir_i + 1'b1;
  assign has_next_o = 1'b1;
`endif

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: N-approach signal controller with yellow/all-red
// clearance and emergency preemption. Optional demand skipping is compiled in
// by defining TLC_DEMAND_SKIP_EN (see tlc_next_dir).
module traffic_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int N_DIR      = DEF_N_DIR,
  parameter int TW         = DEF_TW,
  parameter int YEL_T      = DEF_YEL_T,
  parameter int ALLRED_T   = DEF_ALLRED_T,
  parameter int EMG_HOLD_T = DEF_EMG_HOLD_T
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [N_DIR*TW-1:0]        green_time,
  input  logic                       emergency_vehicle,
  input  logic [$clog2(N_DIR)-1:0]   emergency_road,
  input  logic [N_DIR-1:0]           vehicle_present,
  output logic [3*N_DIR-1:0]         lights,
  output logic [$clog2(N_DIR)-1:0]   active_dir,
  output logic                       emg_active
);

  localparam int DW = $clog2(N_DIR);
  localparam logic [TW-1:0] YEL_END    = TW'(YEL_T - 1);
  localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] HOLD_END   = TW'(EMG_HOLD_T - 1);

  tlc_state_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic [DW-1:0]        tgt_q, tgt_d;     // latched emergency target
  logic                 pend_q, pend_d;   // emergency accepted, awaiting clearance
  logic [3*N_DIR-1:0]   lights_q;
  logic [DW-1:0]        active_dir_q;
  logic                 emg_active_q;

  logic [N_DIR-1:0][TW-1:0] gt_arr;
  logic [TW-1:0]            green_end;
  logic [DW-1:0]            road_c;
  logic [DW-1:0]            next_dir;
  logic                     has_next;

  assign gt_arr    = green_time;
  // A zero green field behaves as a one-tick green.
  assign green_end = (gt_arr[dir_q] == '0) ? '0 : gt_arr[dir_q] - 1'b1;

  // Out-of-range emergency targets fall back to approach 0.
  always_comb begin
    road_c = '0;
    for (int i = 0; i < N_DIR; i++)
      if (emergency_road == DW'(i)) road_c = emergency_road;
  end

  tlc_next_dir #(.N_DIR(N_DIR), .DW(DW)) u_next (
    .cur_dir_i         (dir_q),
    .vehicle_present_i (vehicle_present),
    .next_dir_o        (next_dir),
    .has_next_o        (has_next)
  );

  function automatic logic [3*N_DIR-1:0] lamps(tlc_state_e st, logic [DW-1:0] d);
    logic [3*N_DIR-1:0] v;
    for (int i = 0; i < N_DIR; i++)
      v[3*i +: 3] = (d == DW'(i)) ? served_lamp(st) : LAMP_RED;
    return v;
  endfunction

  // Next-state: phase timing, emergency intake and approach rotation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    case (state_q)
      ST_GREEN: begin
        if (emergency_vehicle) begin
          // Preemption acts at once, independent of tick.
          timer_d = '0;
          tgt_d   = road_c;
          state_d = (road_c == dir_q) ? ST_EMG_GREEN : ST_EMG_CLEAR;
        end else if (tick) begin
          if (timer_q == green_end) begin
            timer_d = '0;
            // No demand elsewhere: restart this green instead of clearing.
            if (has_next) state_d = ST_YELLOW;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_YELLOW: begin
        if (emergency_vehicle && !pend_q) begin
          pend_d = 1'b1;
          tgt_d  = road_c;
        end
        if (tick) begin
          if (timer_q == YEL_END) begin
            timer_d = '0;
            state_d = ST_ALLRED;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_ALLRED: begin
        if (emergency_vehicle && !pend_q) begin
          pend_d = 1'b1;
          tgt_d  = road_c;
        end
        if (tick) begin
          if (timer_q == ALLRED_END) begin
            timer_d = '0;
            if (pend_d) begin
              state_d = ST_EMG_GREEN;
              dir_d   = tgt_d;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_GREEN;
              dir_d   = has_next ? next_dir : dir_q;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_EMG_CLEAR: begin
        if (tick) begin
          if (timer_q == YEL_END) begin
            timer_d = '0;
            state_d = ST_ALLRED;
            pend_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_EMG_GREEN: begin
        // Hold timer only runs once the request is gone; reassertion restarts it.
        if (emergency_vehicle) begin
          timer_d = '0;
        end else if (tick) begin
          if (timer_q == HOLD_END) begin
            timer_d = '0;
            state_d = ST_YELLOW;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_GREEN;
        timer_d = '0;
        dir_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State registers and registered lamp/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GREEN;
      timer_q      <= '0;
      dir_q        <= '0;
      tgt_q        <= '0;
      pend_q       <= 1'b0;
      lights_q     <= lamps(ST_GREEN, '0);
      active_dir_q <= '0;
      emg_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      tgt_q        <= tgt_d;
      pend_q       <= pend_d;
      lights_q     <= lamps(state_d, dir_d);
      active_dir_q <= dir_d;
      emg_active_q <= (state_d == ST_EMG_CLEAR) || (state_d == ST_EMG_GREEN);
    end
  end

  assign lights     = lights_q;
  assign active_dir = active_dir_q;
  assign emg_active = emg_active_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer (N_DIR=4, default timings).
// Driver applies inputs on the falling edge and pushes the expected outputs
// after the next rising edge; the monitor pops and compares after that edge.
module tb_traffic_phase_sequencer;

  localparam int N = 4;
  localparam int YEL_T = 2, ALLRED_T = 1, HOLD_T = 3;
  localparam int PH_G = 0, PH_Y = 1, PH_A = 2, PH_EC = 3, PH_EG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [31:0] gt = {4{8'd3}};
  logic        ev = 1'b0;
  logic [1:0]  road = 2'd0;
  logic [3:0]  vp = 4'b0000;
  logic [11:0] lights;
  logic [1:0]  adir;
  logic        emg;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(.N_DIR(N), .TW(8), .YEL_T(YEL_T), .ALLRED_T(ALLRED_T),
                            .EMG_HOLD_T(HOLD_T)) dut (
    .clk(clk), .rst(rst), .tick(tick), .green_time(gt),
    .emergency_vehicle(ev), .emergency_road(road), .vehicle_present(vp),
    .lights(lights), .active_dir(adir), .emg_active(emg)
  );

  typedef struct {
    logic [11:0] l;
    logic [1:0]  d;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_tot = 0, n_pass = 0, ncyc = 0;
  logic [31:0] gt_next = {4{8'd3}};
  logic [3:0]  vp_next = 4'b0000;

  // Reference model: current phase, served approach, ticks elapsed in phase,
  // pending emergency target (-1 when none).
  int m_ph = PH_G, m_srv = 0, m_el = 0, m_tgt = -1;

  function automatic int green_of(int d);
    int g;
    g = int'(gt[8*d +: 8]);
    return (g == 0) ? 1 : g;
  endfunction

  function automatic int dur();
    case (m_ph)
      PH_G:        return green_of(m_srv);
      PH_Y, PH_EC: return YEL_T;
      PH_A:        return ALLRED_T;
      default:     return HOLD_T;
    endcase
  endfunction

  function automatic int pick_next(int d);
`ifdef TLC_DEMAND_SKIP_EN
    for (int k = 1; k < N; k++) if (vp[(d + k) % N]) return (d + k) % N;
    return -1;
`else
    return (d + 1) % N;
`endif
  endfunction

  task automatic model_step(input bit r, input bit t, input bit e, input int rd_in);
    int rd, n;
    rd = (rd_in >= N) ? 0 : rd_in;
    if (r) begin m_ph = PH_G; m_srv = 0; m_el = 0; m_tgt = -1; return; end
    if (e && m_ph == PH_G) begin
      m_el = 0;
      if (rd == m_srv) begin m_ph = PH_EG; m_tgt = -1; end
      else begin m_ph = PH_EC; m_tgt = rd; end
      return;
    end
    if (e && (m_ph == PH_Y || m_ph == PH_A) && m_tgt < 0) m_tgt = rd;
    if (e && m_ph == PH_EG) begin m_el = 0; return; end
    if (!t) return;
    if (m_el + 1 < dur()) begin m_el++; return; end
    m_el = 0;
    case (m_ph)
      PH_G: begin n = pick_next(m_srv); if (n >= 0) m_ph = PH_Y; end
      PH_Y, PH_EC: m_ph = PH_A;
      PH_A: begin
        if (m_tgt >= 0) begin m_ph = PH_EG; m_srv = m_tgt; m_tgt = -1; end
        else begin n = pick_next(m_srv); if (n >= 0) m_srv = n; m_ph = PH_G; end
      end
      default: m_ph = PH_Y;
    endcase
  endtask

  function automatic logic [11:0] model_lamps();
    logic [11:0] v;
    logic [2:0]  s;
    s = (m_ph == PH_G || m_ph == PH_EG) ? 3'b001 :
        (m_ph == PH_Y || m_ph == PH_EC) ? 3'b010 : 3'b100;
    for (int i = 0; i < N; i++) v[3*i +: 3] = (i == m_srv) ? s : 3'b100;
    return v;
  endfunction

  // One cycle of stimulus. idx>=0 selects the closed-form reset-and-run
  // expectation (green 3, yellow 2, all-red 1 per approach) instead of the model.
  task automatic cyc(input bit r, input bit t, input bit e, input logic [1:0] rd, input int idx);
    exp_t x;
    int a, s;
    @(negedge clk);
    rst = r; tick = t; ev = e; road = rd; vp = vp_next;
    if (r) gt = gt_next;
    model_step(r, t, e, int'(rd));
    if (idx >= 0) begin
      a = (idx / 6) % N;
      s = idx % 6;
      for (int i = 0; i < N; i++)
        x.l[3*i +: 3] = (i != a) ? 3'b100 : (s < 3) ? 3'b001 : (s < 5) ? 3'b010 : 3'b100;
      x.d = a[1:0];
      x.e = 1'b0;
    end else begin
      x.l = model_lamps();
      x.d = m_srv[1:0];
      x.e = (m_ph == PH_EC || m_ph == PH_EG);
    end
    x.cyc = ncyc++;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", nm, c, act, req);
  endtask

  // Monitor: outputs are valid every cycle after the rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("lights", 32'(lights), 32'(x.l), x.cyc);
        chk("active_dir", 32'(adir), 32'(x.d), x.cyc);
        chk("emg_active", 32'(emg), 32'(x.e), x.cyc);
      end
    end
  end

  initial begin
    bit ev_on;
    // Full normal rotation from reset, checked against closed-form timing.
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 24; i++) cyc(0, 1, 0, 0, i);

    // Preempt to approach 2 from GREEN(0), then release.
    cyc(1, 1, 0, 0, -1);
    for (int i = 0; i < 6; i++)  cyc(0, 1, 1, 2'd2, -1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 2'd0, -1);

    // Preempt the served approach 1, drop / reassert / drop.
    cyc(1, 1, 0, 0, -1);
    for (int i = 0; i < 6; i++)  cyc(0, 1, 0, 0, -1);
    cyc(0, 1, 1, 2'd1, -1);
    for (int i = 0; i < 2; i++)  cyc(0, 1, 1, 2'd3, -1);
    for (int i = 0; i < 2; i++)  cyc(0, 1, 0, 2'd3, -1);
    cyc(0, 1, 1, 2'd0, -1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 2'd0, -1);

    // Reset in the middle of emergency clearance.
    cyc(1, 1, 0, 0, -1);
    cyc(0, 1, 1, 2'd3, -1);
    cyc(0, 1, 1, 2'd3, -1);
    cyc(1, 1, 1, 2'd3, -1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2'd0, -1);

`ifdef TLC_DEMAND_SKIP_EN
    vp_next = 4'b0100;
    cyc(1, 1, 0, 0, -1);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, -1);
    vp_next = 4'b0000;
    cyc(1, 1, 0, 0, -1);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, -1);
`endif

    // Randomized traffic: gaps in tick, emergency bursts, occasional reset.
    ev_on = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 149) == 0);
      if (r) for (int k = 0; k < N; k++) gt_next[8*k +: 8] = 8'($urandom_range(0, 4));
      if ((i % 8) == 0) vp_next = 4'($urandom);
      if ($urandom_range(0, 11) == 0) ev_on = ~ev_on;
      cyc(r, ($urandom_range(0, 3) != 0), ev_on, 2'($urandom), -1);
    end

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 SHALL have parameter N_DIR, default 4: number of approaches, 2..8.
REQ-002 SHALL have parameter TW, default 8: width of each green-time field and of the phase timer.
REQ-003 SHALL have parameter YEL_T, default 2: yellow duration in ticks, >=1.
REQ-004 SHALL have parameter ALLRED_T, default 1: all-red clearance in ticks, >=1.
REQ-005 SHALL have parameter EMG_HOLD_T, default 3: emergency green hold after request drops, in ticks, >=1.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1: timebase enable; timers advance only on cycles with tick=1.
REQ-009 SHALL have port green_time, input, N_DIR*TW: green duration for approach d in bits [d*TW +: TW].
REQ-010 SHALL have port emergency_vehicle, input, 1: preemption request, level-sensitive.
REQ-011 SHALL have port emergency_road, input, DW=$clog2(N_DIR): approach to preempt to.
REQ-012 SHALL have port vehicle_present, input, N_DIR: per-approach demand (see REQ-029).
REQ-013 SHALL have port lights, output, 3*N_DIR: approach d in [3*d +: 3], ordered {R,Y,G}.
REQ-014 SHALL have port active_dir, output, DW: approach currently served.
REQ-015 SHALL have port emg_active, output, 1: high in EMG_CLEAR and EMG_GREEN.

Function
REQ-016 SHALL implement a registered FSM with states GREEN, YELLOW, ALLRED, EMG_CLEAR, EMG_GREEN, plus a TW-bit phase timer and a DW-bit served-approach register.
REQ-017 SHALL end a phase of duration D on the cycle where tick=1 and timer==D-1; the timer then clears and the state changes on that clock edge.
REQ-018 SHALL treat a green_time field of 0 as 1.
REQ-019 SHALL drive outputs from registered state only: the served approach is 001 in GREEN and EMG_GREEN, 010 in YELLOW and EMG_CLEAR, and all other approaches are 100; every approach is 100 in ALLRED.
REQ-020 SHALL follow the normal sequence GREEN(d) -> YELLOW(d) -> ALLRED -> GREEN(next(d)), where next wraps from N_DIR-1 to 0.
REQ-021 SHALL never show green or yellow on two approaches in the same cycle.
REQ-022 SHALL sample emergency_vehicle=1 in GREEN(d) and respond as follows: if emergency_road==d, go to EMG_GREEN(d) next cycle with no clearance; otherwise go to EMG_CLEAR(d) for YEL_T ticks, then ALLRED, then EMG_GREEN(emergency_road).
REQ-023 SHALL sample emergency_vehicle=1 in YELLOW or ALLRED without restarting clearance: finish the current clearance, then enter EMG_GREEN(emergency_road) instead of the next GREEN.
REQ-024 SHALL latch the emergency_road target at request acceptance; changes to emergency_road during EMG_CLEAR or EMG_GREEN are ignored.
REQ-025 SHALL hold EMG_GREEN while emergency_vehicle=1, then hold it for EMG_HOLD_T ticks after deassertion; reassertion during the hold restarts the hold.
REQ-026 SHALL exit EMG_GREEN(e) via YELLOW(e) and ALLRED, then resume at GREEN(next(e)).
REQ-027 SHALL treat an emergency_road value >= N_DIR as approach 0.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state GREEN, served approach 0, timer 0, lights = approach 0 001 and all others 100, active_dir=0, and emg_active=0; rst SHALL override tick and every other input, including mid-emergency.

Configuration
REQ-029 SHALL compile in demand skipping when macro TLC_DEMAND_SKIP_EN is defined: next(d) becomes the first approach after d, cyclically, with vehicle_present=1; if none has demand, GREEN(d) is held, restarting its green_time, with no yellow. Without the macro, vehicle_present is ignored and next(d) = d+1 mod N_DIR.

Structure
REQ-030 SHALL place the state enum, the {R,Y,G} lamp constants (RED=100, YEL=010, GRN=001) and the default durations in a shared package, tlc_pkg.
REQ-031 SHALL isolate next-approach selection, including the demand-skip priority rotate, in sub-module tlc_next_dir.

Verification
REQ-032 SHALL verify: N_DIR=4, green_time all 3, tick every cycle, no emergency -> after reset, approach 0 green for 3 cycles, yellow for 2, all-red for 1, then approach 1 green; the full cycle is 24 cycles.
REQ-033 SHALL verify: emergency_vehicle=1, emergency_road=2 during GREEN(0) -> approach 0 yellow for 2 ticks, all-red for 1, approach 2 green, emg_active=1.
REQ-034 SHALL verify: emergency on the served approach 1 during GREEN(1) -> EMG_GREEN(1) on the next cycle, lights unchanged at 001.
REQ-035 SHALL verify: emergency drops, then reasserts after 2 ticks -> EMG_GREEN is held until 3 ticks after the final drop, then YELLOW(e), ALLRED, GREEN(e+1).
REQ-036 SHALL verify: TLC_DEMAND_SKIP_EN defined, vehicle_present=0100 in GREEN(0) -> next green is approach 2; with vehicle_present=0000, approach 0 stays green indefinitely.
REQ-037 SHALL verify: rst asserted during EMG_CLEAR -> next cycle shows approach 0 green, emg_active=0, timer 0.
